// File: rtl/mem_lsu_if.sv
// Data-bus bundle between the load/store unit (master) and the data memory (slave).
interface mem_lsu_if;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    modport master (
        output bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        input  bus_rdata_i, bus_ack_i
    );

    modport slave (
        input  bus_req_o, bus_we_o, bus_addr_o, bus_sel_o, bus_wdata_o,
        output bus_rdata_i, bus_ack_i
    );
endinterface

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: big-endian byte lanes, stalls the pipeline across a bus transfer.
// Optional LL/SC link bit enabled by defining LLSC_EN.
module mem_lsu (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    mem_lsu_if.master   bus,
    output logic        stallreq_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        align_err_o
`ifdef LLSC_EN
    ,
    input  logic        llbit_clr_i
`endif
);

    localparam logic [7:0] OP_LB  = 8'b11100000;
    localparam logic [7:0] OP_LBU = 8'b11100100;
    localparam logic [7:0] OP_LH  = 8'b11100001;
    localparam logic [7:0] OP_LHU = 8'b11100101;
    localparam logic [7:0] OP_LW  = 8'b11100011;
    localparam logic [7:0] OP_LL  = 8'b11110000;
    localparam logic [7:0] OP_SB  = 8'b11101000;
    localparam logic [7:0] OP_SH  = 8'b11101001;
    localparam logic [7:0] OP_SW  = 8'b11101011;
    localparam logic [7:0] OP_SC  = 8'b11111000;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
    state_t state, state_nxt;

    logic        dec_mem, dec_we, dec_sgn;
    logic [1:0]  dec_size;
    logic [3:0]  dec_sel;
    logic [31:0] dec_wdata;
    logic        misalign, sc_fail, start;

    logic [29:0] q_waddr;
    logic [3:0]  q_sel;
    logic        q_we, q_sgn, q_wreg;
    logic [31:0] q_wdata;
    logic [1:0]  q_size, q_off;
    logic [4:0]  q_wd;
    logic [31:0] rdata_q;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
`ifdef LLSC_EN
    logic        dec_ll, dec_sc, q_ll, q_sc, llbit;
`endif

    always_comb begin
        dec_mem  = 1'b0;
        dec_we   = 1'b0;
        dec_sgn  = 1'b0;
        dec_size = SZ_WORD;
`ifdef LLSC_EN
        dec_ll   = 1'b0;
        dec_sc   = 1'b0;
`endif
        case (aluop_i)
            OP_LB:  begin dec_mem = 1'b1; dec_size = SZ_BYTE; dec_sgn = 1'b1; end
            OP_LBU: begin dec_mem = 1'b1; dec_size = SZ_BYTE; end
            OP_LH:  begin dec_mem = 1'b1; dec_size = SZ_HALF; dec_sgn = 1'b1; end
            OP_LHU: begin dec_mem = 1'b1; dec_size = SZ_HALF; end
            OP_LW:  dec_mem = 1'b1;
            OP_LL:  begin
                dec_mem = 1'b1;
`ifdef LLSC_EN
                dec_ll  = 1'b1;
`endif
            end
            OP_SB:  begin dec_mem = 1'b1; dec_we = 1'b1; dec_size = SZ_BYTE; end
            OP_SH:  begin dec_mem = 1'b1; dec_we = 1'b1; dec_size = SZ_HALF; end
            OP_SW:  begin dec_mem = 1'b1; dec_we = 1'b1; end
            OP_SC:  begin
                dec_mem = 1'b1;
                dec_we  = 1'b1;
`ifdef LLSC_EN
                dec_sc  = 1'b1;
`endif
            end
            default: ;
        endcase
    end

    // Lane 0 is the most significant byte (big-endian); sub-word stores replicate across lanes.
    always_comb begin
        case (dec_size)
            SZ_BYTE: begin
                dec_sel   = 4'b1000 >> mem_addr_i[1:0];
                dec_wdata = {4{reg2_i[7:0]}};
            end
            SZ_HALF: begin
                dec_sel   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
                dec_wdata = {2{reg2_i[15:0]}};
            end
            default: begin
                dec_sel   = '1;
                dec_wdata = reg2_i;
            end
        endcase
    end

    always_comb begin
        misalign = dec_mem && ((dec_size == SZ_HALF && mem_addr_i[0]) ||
                               (dec_size == SZ_WORD && mem_addr_i[1:0] != 2'b00));
`ifdef LLSC_EN
        sc_fail  = dec_sc && !llbit;
`else
        sc_fail  = 1'b0;
`endif
        start    = dec_mem && !misalign && !sc_fail;
    end

    // Request attributes are frozen on issue so the bus sees them stable during REQ.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_waddr <= '0;
            q_sel   <= '0;
            q_we    <= 1'b0;
            q_wdata <= '0;
            q_size  <= '0;
            q_off   <= '0;
            q_sgn   <= 1'b0;
            q_wd    <= '0;
            q_wreg  <= 1'b0;
            rdata_q <= '0;
`ifdef LLSC_EN
            q_ll    <= 1'b0;
            q_sc    <= 1'b0;
`endif
        end else begin
            if (state == IDLE && start) begin
                q_waddr <= mem_addr_i[31:2];
                q_sel   <= dec_sel;
                q_we    <= dec_we;
                q_wdata <= dec_wdata;
                q_size  <= dec_size;
                q_off   <= mem_addr_i[1:0];
                q_sgn   <= dec_sgn;
                q_wd    <= wd_i;
                q_wreg  <= wreg_i;
`ifdef LLSC_EN
                q_ll    <= dec_ll;
                q_sc    <= dec_sc;
`endif
            end
            if (state == REQ && bus.bus_ack_i)
                rdata_q <= bus.bus_rdata_i;
        end
    end

`ifdef LLSC_EN
    always_ff @(posedge clk) begin
        if (rst || llbit_clr_i)
            llbit <= 1'b0;
        else if (state == DONE && q_ll)
            llbit <= 1'b1;
        else if (state == DONE && q_sc)
            llbit <= 1'b0;
    end
`endif

    always_comb begin
        case (q_off)
            2'd0:    ld_byte = rdata_q[31:24];
            2'd1:    ld_byte = rdata_q[23:16];
            2'd2:    ld_byte = rdata_q[15:8];
            default: ld_byte = rdata_q[7:0];
        endcase
        ld_half = q_off[1] ? rdata_q[15:0] : rdata_q[31:16];
        case (q_size)
            SZ_BYTE: ld_data = {{24{q_sgn & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data = {{16{q_sgn & ld_half[15]}}, ld_half};
            default: ld_data = rdata_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ:     if (bus.bus_ack_i) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.bus_req_o   = 1'b0;
        bus.bus_we_o    = 1'b0;
        bus.bus_addr_o  = '0;
        bus.bus_sel_o   = '0;
        bus.bus_wdata_o = '0;
        stallreq_o      = 1'b0;
        wd_o            = '0;
        wreg_o          = 1'b0;
        wdata_o         = '0;
        align_err_o     = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (!dec_mem) begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = wdata_i;
                    end else if (misalign) begin
                        align_err_o = 1'b1;
                        wd_o        = wd_i;
                    end else if (sc_fail) begin
                        wd_o   = wd_i;
                        wreg_o = 1'b1;
                    end else begin
                        stallreq_o = 1'b1;
                    end
                end
                REQ: begin
                    bus.bus_req_o   = 1'b1;
                    bus.bus_we_o    = q_we;
                    bus.bus_addr_o  = {q_waddr, 2'b00};
                    bus.bus_sel_o   = q_sel;
                    bus.bus_wdata_o = q_wdata;
                    stallreq_o      = 1'b1;
                end
                DONE: begin
                    wd_o = q_wd;
                    if (!q_we) begin
                        wreg_o  = q_wreg;
                        wdata_o = ld_data;
                    end
`ifdef LLSC_EN
                    else if (q_sc) begin
                        wreg_o  = 1'b1;
                        wdata_o = 32'd1;
                    end
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 aluop_i  input  8  operation from EX/MEM register (codebase EXE_*_OP encodings).
REQ-004 mem_addr_i  input  32  effective byte address.
REQ-005 reg2_i  input  32  store data source.
REQ-006 wd_i / wreg_i / wdata_i  input  5/1/32  destination address, write enable, ALU result.
REQ-007 bus_req_o / bus_we_o  output  1/1  data-bus request, write strobe.
REQ-008 bus_addr_o / bus_sel_o / bus_wdata_o  output  32/4/32  word address (bits[1:0]=00), byte lanes, write data.
REQ-009 bus_rdata_i / bus_ack_i  input  32/1  read data, transfer acknowledge.
REQ-010 stallreq_o  output  1  pipeline hold request to the stall controller.
REQ-011 wd_o / wreg_o / wdata_o  output  5/1/32  results to MEM/WB register.
REQ-012 align_err_o  output  1  one-cycle misaligned-access flag.
REQ-013 llbit_clr_i  input  1  LL bit clear (present only with LLSC_EN).

Function
REQ-014 FSM states IDLE, REQ, DONE; reset state IDLE.
REQ-015 IDLE, non-memory aluop_i: wd_o/wreg_o/wdata_o = inputs combinationally, stallreq_o=0, no bus activity.
REQ-016 IDLE, aligned load/store: stallreq_o=1 in the same cycle; next state REQ.
REQ-017 REQ: bus_req_o=1; addr/sel/we/wdata held stable; stallreq_o=1; remain until bus_ack_i=1.
REQ-018 REQ with bus_ack_i=1: capture bus_rdata_i, next state DONE; bus_req_o drops next cycle.
REQ-019 DONE: stallreq_o=0, outputs present the captured result; next state IDLE unconditionally (no re-issue of the same instruction).
REQ-020 Minimum load/store latency 2 cycles (arrival to DONE), ack in first REQ cycle.
REQ-021 Big-endian lanes: byte offset 00->sel 1000 / rdata[31:24]; 01->0100; 10->0010; 11->0001; halfword 00->1100, 10->0011; word sel 1111.
REQ-022 LB/LH sign-extend; LBU/LHU zero-extend; LW full word; load wreg_o = wreg_i.
REQ-023 SB/SH replicate reg2_i low byte/halfword across all lanes; store wreg_o=0.
REQ-024 Misaligned halfword (addr[0]=1) or word (addr[1:0]!=00): no bus access, no stall, align_err_o=1 for one cycle, wreg_o=0.
REQ-025 Bus outputs zero whenever bus_req_o=0.

Reset
REQ-026 rst=1 on a clock edge: state IDLE, captured data 0, bus_req_o 0, stallreq_o 0, align_err_o 0, LL bit 0; outputs all zero while rst=1.
REQ-027 rst mid-REQ: transfer abandoned, bus_req_o=0 from next cycle, ignoring late acks.

Configuration
REQ-028 Macro LLSC_EN defined: llbit_clr_i exists; LL = aligned LW setting LL bit at DONE; SC with LL bit=1 stores word, wdata_o=1, wreg_o=1, clears LL bit; SC with LL bit=0: no bus access, no stall, wdata_o=0, wreg_o=1; llbit_clr_i clears LL bit (priority over LL set).
REQ-029 LLSC_EN undefined: no LL bit, no llbit_clr_i; LL behaves as LW, SC as SW with wreg_o=0.

Verification
REQ-030 LB addr 0x103, rdata 0x000000F0, ack after 3 REQ cycles -> sel 0001, stallreq 4 cycles, wdata_o 0xFFFFFFF0.
REQ-031 SH addr 0x202, reg2 0x1234ABCD -> sel 0011, bus_wdata 0xABCDABCD, we=1, wreg_o=0.
REQ-032 LW addr 0x105 -> bus_req_o never asserted, align_err_o one cycle, wreg_o=0, stallreq_o=0.
REQ-033 rst asserted during REQ, ack next cycle -> IDLE, bus_req_o 0, outputs 0, no result written.
REQ-034 (LLSC_EN) LL 0x300, SC 0x300 -> store issued, wdata_o=1; repeat SC -> no bus access, wdata_o=0.
REQ-035 ADDU back-to-back with LW -> ADDU result passes zero latency; LW stalls until DONE.
